// File: rtl/mux8way_scan_reader.sv
// Snapshots eight words plus an enable mask on start, then streams the
// enabled words in ascending select order over a valid/ready interface.
module mux8way_scan_reader #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [8*WIDTH-1:0] words_in,
    input  logic [7:0]         mask_in,
    input  logic               start,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_sel,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] snap_q [8];
    logic [WIDTH-1:0] snap_d [8];
    logic [7:0]       mask_q, mask_d;
    logic [2:0]       idx_q, idx_d;

    logic [2:0]       first_sel;
    logic [2:0]       next_sel;
    logic             last_beat;

    // Lowest set bit of m at position >= from (0 if none).
    function automatic logic [2:0] low_bit_from(
        input logic [7:0] m,
        input int         from
    );
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (i >= from)) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction

    always_comb begin
        first_sel = low_bit_from(mask_in, 0);
        next_sel  = low_bit_from(mask_q, int'(idx_q) + 1);
        last_beat = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (mask_q[i] && (i > int'(idx_q))) begin
                last_beat = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mask_q  <= 8'd0;
            idx_q   <= 3'd0;
            for (int k = 0; k < 8; k++) begin
                snap_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            for (int k = 0; k < 8; k++) begin
                snap_q[k] <= snap_d[k];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        idx_d     = idx_q;
        for (int k = 0; k < 8; k++) begin
            snap_d[k] = snap_q[k];
        end
        out_valid = 1'b0;
        out_data  = '0;
        out_sel   = 3'd0;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int k = 0; k < 8; k++) begin
                        snap_d[k] = words_in[k*WIDTH +: WIDTH];
                    end
                    mask_d = mask_in;
                    idx_d  = first_sel;
                    // An empty mask skips straight to the done pulse.
                    if (mask_in != 8'd0) begin
                        state_d = S_STREAM;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_STREAM: begin
                out_valid = 1'b1;
                out_data  = snap_q[idx_q];
                out_sel   = idx_q;
                out_last  = last_beat;
                busy      = 1'b1;
                if (out_ready) begin
                    if (last_beat) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = next_sel;
                    end
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux8way_scan_reader.sv
// Scoreboard bench for mux8way_scan_reader: stimulus pushes expected beats,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mux8way_scan_reader;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [8*W-1:0] words_in;
    logic [7:0]     mask_in;
    logic           start;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   out_data;
    logic [2:0]     out_sel;
    logic           out_last;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    mux8way_scan_reader #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .words_in  (words_in),
        .mask_in   (mask_in),
        .start     (start),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic [2:0]   sel;
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    exp_done = 1'b0;
    bit    mon_en = 1'b0;
    int    xfers = 0;
    int    rdy_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: enabled words in ascending order, last = highest enabled.
    task automatic push_model(input logic [8*W-1:0] w, input logic [7:0] m);
        int    hi;
        beat_t b;
        hi = -1;
        for (int k = 0; k < 8; k++) if (m[k]) hi = k;
        for (int k = 0; k < 8; k++) begin
            if (m[k]) begin
                b.sel  = 3'(k);
                b.data = w[k*W +: W];
                b.last = (k == hi);
                exp_q.push_back(b);
            end
        end
    endtask

    // 0: always ready, 1: toggle, 2: random
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        beat_t b;
        if (mon_en && rst_n) begin
            chk("done", done, exp_done);
            exp_done = 1'b0;
            if (!busy) begin
                chk("idle_valid", out_valid, 0);
                chk("idle_sel", out_sel, 0);
                chk("idle_data", out_data, 0);
                chk("idle_last", out_last, 0);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    b = exp_q[0];
                    chk("sel", out_sel, b.sel);
                    chk("data", out_data, b.data);
                    chk("last", out_last, b.last);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        xfers++;
                        if (b.last) exp_done = 1'b1;
                    end
                end
            end
        end
    end

    // mode 1: scramble inputs after start; mode 2: poke start mid-stream
    task automatic run_scan(input logic [8*W-1:0] w, input logic [7:0] m,
                            input int mode, output int cyc);
        int t;
        @(posedge clk);
        #1;
        t = 0;
        while (busy && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("idle_wait_timeout", busy, 0);
        words_in = w;
        mask_in  = m;
        start    = 1'b1;
        push_model(w, m);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (m == 8'd0) exp_done = 1'b1;
        if (mode == 1) begin
            words_in = '1;
            mask_in  = ~m;
        end
        cyc = 0;
        while (busy && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (mode == 2 && cyc == 2) begin
                start    = 1'b1;
                mask_in  = 8'h01;
                words_in = '0;
            end
            if (mode == 2 && cyc == 3) start = 1'b0;
        end
        chk("scan_timeout", busy, 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        logic [8*W-1:0] w;
        int             cyc;
        int             base;
        int             t;

        rst_n    = 1'b0;
        start    = 1'b0;
        words_in = '0;
        mask_in  = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sel", out_sel, 0);
        chk("rst_data", out_data, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int k = 0; k < 8; k++) w[k*W +: W] = 16'h1000 + 16'(k);
        run_scan(w, 8'hFF, 0, cyc);
        chk("full_scan_cycles", cyc, 9);

        rdy_mode = 1;
        for (int k = 0; k < 8; k++) w[k*W +: W] = W'($urandom);
        run_scan(w, 8'b1010_0100, 0, cyc);

        rdy_mode = 0;
        for (int k = 0; k < 8; k++) w[k*W +: W] = W'($urandom);
        run_scan(w, 8'hFF, 1, cyc);

        run_scan(w, 8'h00, 0, cyc);
        chk("empty_scan_cycles", cyc, 1);

        for (int k = 0; k < 8; k++) w[k*W +: W] = W'($urandom);
        @(posedge clk);
        #1;
        words_in = w;
        mask_in  = 8'hFF;
        start    = 1'b1;
        push_model(w, 8'hFF);
        base = xfers;
        @(posedge clk);
        #1;
        start = 1'b0;
        t = 0;
        while (xfers - base < 3 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("three_beats", xfers - base, 3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_done = 1'b0;
        @(negedge clk);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) w[k*W +: W] = W'($urandom);
        run_scan(w, 8'hFF, 2, cyc);
        chk("restart_cycles", cyc, 9);

        rdy_mode = 2;
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 8; k++) w[k*W +: W] = W'($urandom);
            run_scan(w, 8'($urandom_range(0, 255)), i % 2, cyc);
        end

        rdy_mode = 0;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
